mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand, HI and LO width.
REQ-002 SHALL have port w_clock, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port w_reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port w_start_1, input, 1, request strobe from the ALU/issue stage.
REQ-005 SHALL have port w_op_code_6, input, 6, function code: SPECIAL_MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have ports w_input1_x and w_input2_x, input, WIDTH, rs (multiplicand/dividend/MT data) and rt.
REQ-007 SHALL have port w_busy_1, output, 1, operation in flight; pipeline stalls MFHI/MFLO while high.
REQ-008 SHALL have port w_done_1, output, 1, one-cycle pulse when HI/LO are updated by MULT/DIV.
REQ-009 SHALL have port w_dz_1, output, 1, divide-by-zero flag, valid only with w_done_1.
REQ-010 SHALL have ports w_hi_x and w_lo_x, output, WIDTH, current HI and LO register contents.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, SIGN; w_busy_1 = (state != IDLE).
REQ-012 SHALL accept a request only when w_start_1=1 in IDLE; w_start_1 in RUN/SIGN is ignored with no effect.
REQ-013 SHALL, for MTHI/MTLO accepted in IDLE, write w_input1_x to HI/LO at that edge, stay IDLE, no w_done_1.
REQ-014 SHALL ignore w_start_1 with any other opcode (state, HI, LO unchanged).
REQ-015 SHALL, on accepting MULT/MULTU/DIV/DIVU, latch magnitudes, result signs, op type and go to RUN with iteration counter = 0.
REQ-016 SHALL perform exactly WIDTH RUN cycles: one shift-add bit per cycle for multiply, one restoring subtract bit per cycle for divide.
REQ-017 SHALL, in SIGN (one cycle), apply sign correction, write HI/LO, assert w_done_1, and go to IDLE at the next edge.
REQ-018 SHALL give a fixed latency: request accepted at edge 0, w_done_1 high and w_hi_x/w_lo_x new during cycle WIDTH+1 (33 for WIDTH=32).
REQ-019 SHALL produce for multiply {HI,LO} = full 2*WIDTH product; signed for MULT, unsigned for MULTU.
REQ-020 SHALL produce for divide LO=quotient, HI=remainder; signed DIV truncates toward zero, remainder takes dividend's sign.
REQ-021 SHALL, for divisor 0, set LO = all ones, HI = dividend (raw rs), w_dz_1=1 with w_done_1; latency unchanged.
REQ-022 SHALL, for signed DIV of most-negative / -1, give LO = most-negative value, HI = 0, w_dz_1=0.
REQ-023 SHALL keep w_hi_x/w_lo_x at previous values throughout RUN; update only in SIGN or on MTHI/MTLO.
REQ-024 SHALL hold w_done_1 and w_dz_1 low in all cycles except the SIGN cycle.

Reset
REQ-025 SHALL, on w_reset_n=0 at any time including mid-RUN, immediately force state IDLE, HI=0, LO=0, counter=0, w_busy_1=0, w_done_1=0, w_dz_1=0.
REQ-026 SHALL abandon any in-flight operation on reset; no partial result reaches HI/LO.
REQ-027 SHALL accept a new request on the first rising edge with w_reset_n=1.

Configuration
REQ-028 SHALL compile the divider in only when macro MULT_DIV_UNIT_DIV_EN is defined.
REQ-029 SHALL, without MULT_DIV_UNIT_DIV_EN, treat DIV/DIVU as unsupported per REQ-014 (w_dz_1 tied 0); multiply, MTHI, MTLO unchanged.

Structure
REQ-030 SHALL take opcode constants (SPECIAL_MULT, _MULTU, _DIV, _DIVU, _MTHI, _MTLO) from shared isa_codes definitions; FSM state encodings live in the same shared package.
REQ-031 SHALL place the one-bit-per-cycle restoring divide datapath in sub-module mdu_div_step; multiply datapath and FSM stay in mult_div_unit.

Verification
REQ-032 SHALL cover: MULT rs=-3 (0xFFFFFFFD), rt=7 -> cycle 33 done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high cycles 1-33.
REQ-033 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 SHALL cover: DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 7/0 -> LO=0xFFFFFFFF, HI=7, dz=1.
REQ-035 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, dz=0.
REQ-036 SHALL cover: MTHI 0x1234 in IDLE -> HI=0x1234 next cycle, no done; start MULT then pulse w_start_1 with MTLO at cycle 5 -> ignored, LO = product only.
REQ-037 SHALL cover: w_reset_n low at cycle 10 of a MULT -> outputs 0 immediately, no done; new MULTU 2x3 after release -> LO=6 after 33 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared ISA function codes and state encodings for the multiply/divide unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mult_div_unit_pkg;

  // ISA SPECIAL-class function codes handled by the unit
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;
  localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
  localparam logic [5:0] SPECIAL_MTLO  = 6'h13;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step: shifts one dividend bit into the remainder.
// Latency: combinational, one quotient bit per evaluation.
// Backpressure: none; the caller sequences the steps.
module mdu_div_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  // Remainder stays below divisor, so {rem,bit} < 2*divisor; two spare bits
  // keep the trial difference's sign unambiguous.
  logic [WIDTH+1:0] w_trial;

  // Trial subtract; restore (keep shifted remainder) when it goes negative
  always_comb begin
    w_trial = {1'b0, i_rem, i_quo[WIDTH-1]} - {2'b00, i_dvsr};
    if (w_trial[WIDTH+1]) begin
      o_rem = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end else begin
      o_rem = w_trial[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU (and DIV/DIVU when MULT_DIV_UNIT_DIV_EN is defined) with HI/LO registers.
// Latency: accept at edge 0, done pulse and new HI/LO visible in cycle WIDTH+1.
// Backpressure: busy high while in flight; starts during RUN/SIGN are dropped.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic             w_start_1,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  output logic             w_busy_1,
  output logic             w_done_1,
  output logic             w_dz_1,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opnd;
  logic             r_is_div, r_neg_lo, r_neg_hi, r_dz;

  logic             w_is_mul, w_is_div, w_signed, w_accept, w_mt_hi, w_mt_lo;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_div_rem, w_div_quo;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  assign w_is_mul = (w_op_code_6 == SPECIAL_MULT) || (w_op_code_6 == SPECIAL_MULTU);
  assign w_signed = (w_op_code_6 == SPECIAL_MULT) || (w_op_code_6 == SPECIAL_DIV);
  assign w_accept = w_start_1 && (r_state == IDLE) && (w_is_mul || w_is_div);
  assign w_mt_hi  = w_start_1 && (r_state == IDLE) && (w_op_code_6 == SPECIAL_MTHI);
  assign w_mt_lo  = w_start_1 && (r_state == IDLE) && (w_op_code_6 == SPECIAL_MTLO);

  // Operate on magnitudes; signs are reapplied in SIGN
  assign w_a_neg = w_signed & w_input1_x[WIDTH-1];
  assign w_b_neg = w_signed & w_input2_x[WIDTH-1];
  assign w_a_mag = w_a_neg ? -w_input1_x : w_input1_x;
  assign w_b_mag = w_b_neg ? -w_input2_x : w_input2_x;

  // Shift-add: add multiplicand when multiplier LSB (acc_lo[0]) is set
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

`ifdef MULT_DIV_UNIT_DIV_EN
  assign w_is_div = (w_op_code_6 == SPECIAL_DIV) || (w_op_code_6 == SPECIAL_DIVU);

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem  (r_acc_hi),
    .i_quo  (r_acc_lo),
    .i_dvsr (r_opnd),
    .o_rem  (w_div_rem),
    .o_quo  (w_div_quo)
  );

  assign w_dz_1 = w_done_1 & r_dz;
`else
  assign w_is_div  = 1'b0;
  assign w_div_rem = r_acc_hi;
  assign w_div_quo = r_acc_lo;
  assign w_dz_1    = 1'b0;
`endif

  // Sign correction. A zero divisor leaves |rs| in the remainder, and negating
  // by the dividend sign restores raw rs, so only the quotient needs forcing.
  always_comb begin
    w_res_hi = r_acc_hi;
    w_res_lo = r_acc_lo;
    if (r_is_div) begin
      if (r_neg_hi) w_res_hi = -r_acc_hi;
      if (r_dz) w_res_lo = '1;
      else if (r_neg_lo) w_res_lo = -r_acc_lo;
    end else if (r_neg_lo) begin
      {w_res_hi, w_res_lo} = -{r_acc_hi, r_acc_lo};
    end
  end

  // State register
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_done_1    = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = RUN;
      RUN:  if (r_cnt == CW'(WIDTH-1)) w_state_nxt = SIGN;
      SIGN: begin
        w_done_1    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy_1 = (r_state != IDLE);
  assign w_hi_x   = (r_state == SIGN) ? w_res_hi : r_hi;
  assign w_lo_x   = (r_state == SIGN) ? w_res_lo : r_lo;

  // Latch operands on accept, then iterate one bit per RUN cycle
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= w_is_div ? w_a_mag : w_b_mag;
      r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
      r_is_div <= w_is_div;
      r_neg_lo <= w_a_neg ^ w_b_neg;
      r_neg_hi <= w_a_neg;
      r_dz     <= w_is_div && (w_input2_x == '0);
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_is_div) {r_acc_hi, r_acc_lo} <= {w_div_rem, w_div_quo};
      else          {r_acc_hi, r_acc_lo} <= {w_mul_sum[WIDTH:1], w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // Architectural HI/LO: committed at the end of SIGN or by MTHI/MTLO
  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == SIGN) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else begin
      if (w_mt_hi) r_hi <= w_input1_x;
      if (w_mt_lo) r_lo <= w_input1_x;
    end
  end

endmodule
